// File: rtl/utility_ctr_pc_pkg.sv
// Shared constants for the PC / counter utility block: opcodes, CSR map,
// inhibit bit positions and the CSR access FSM state type.
package utility_ctr_pc_pkg;

  // Decoded opcodes handled by this block
  localparam logic [11:0] OP_CSRR   = 12'h073;
  localparam logic [11:0] OP_JAL    = 12'h06F;
  localparam logic [11:0] OP_JALR   = 12'h067;
  localparam logic [11:0] OP_AUIPC  = 12'h017;
  localparam logic [11:0] OP_LUI    = 12'h037;
  localparam logic [6:0]  OP_BR7    = 7'h63;
  localparam logic [11:0] OP_RETIRQ = 12'h398;

  // Counter CSRs live in page C; bit 7 selects the high half and the low
  // nibble is the counter index (cycle, time, instret, hpm0, hpm1, ...).
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_HPM0     = 12'hC03;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_HPM0H    = 12'hC83;
  localparam logic [11:0] CSR_INHIBIT  = 12'h320;
  localparam logic [3:0]  CSR_CNT_PAGE = 4'hC;
  localparam int          CSR_HI_BIT   = 7;

  // Counter-inhibit bit indices (hpm k sits at INH_HPM0 + k)
  localparam int INH_CY   = 0;
  localparam int INH_TM   = 1;
  localparam int INH_IR   = 2;
  localparam int INH_HPM0 = 3;

  typedef enum logic {
    CSR_IDLE = 1'b0,
    CSR_ACK  = 1'b1
  } csr_state_t;

endpackage

// File: rtl/utility_ctr_pc_ctr_unit.sv
// Free-running event counter: increments by one when inc_en is high and
// wraps modulo 2^W.
import utility_ctr_pc_pkg::*;

module ctr_unit #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_en,
  output logic [W-1:0] value
);

  logic [W-1:0] cnt_q;

  // Count register, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (inc_en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/utility_ctr_pc.sv
// PC register, next-PC selection, rd result mux and the cycle/time/instret/
// hpm counter bank with a one-request-one-ack CSR port.
//
// CSR access FSM:
//   state    | meaning
//   CSR_IDLE | waiting; csr_req sampled here starts an access
//   CSR_ACK  | csr_ack high for this one cycle; csr_req ignored
import utility_ctr_pc_pkg::*;

module utility_ctr_pc #(
  parameter int          CNT_W    = 64,
  parameter int          TIME_DIV = 100,
  parameter int          N_HPM    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_pc,
  input  logic [11:0]      opcode,
  input  logic [31:0]      imm,
  input  logic [31:0]      rs1,
  input  logic             branch,
  input  logic             irr,
  input  logic [31:0]      irr_dest,
  input  logic [31:0]      irr_ret,
  input  logic [N_HPM-1:0] hpm_event,
  input  logic             csr_req,
  input  logic             csr_we,
  input  logic [11:0]      csr_addr,
  input  logic [31:0]      csr_wdata,
  output logic             csr_ack,
  output logic [31:0]      csr_rdata,
  output logic [31:0]      rd,
  output logic             is_rd,
  output logic             is_inst,
  output logic [31:0]      pc,
  output logic             misalign
);

  localparam int N_CNT = 3 + N_HPM;
  localparam int INH_W = 3 + N_HPM;
  localparam int HI_W  = CNT_W - 32;
  localparam int PS_W  = $clog2(TIME_DIV);
  localparam logic [INH_W-1:0] INH_WMASK = ~(INH_W'(1) << INH_TM);

  logic [CNT_W-1:0] cnt_val [N_CNT];
  logic [N_CNT-1:0] cnt_inc;
  logic [INH_W-1:0] inhibit_q;
  logic [PS_W-1:0]  presc_q;
  logic             presc_wrap;

  logic [HI_W-1:0]  shadow_q;
  logic             tag_vld_q;
  logic [3:0]       tag_idx_q;

  csr_state_t       state_q, state_d;
  logic             csr_go;
  logic [3:0]       csr_idx;
  logic             csr_hi;
  logic             cnt_hit;
  logic             tag_match;
  logic [31:0]      sel_lo;
  logic [HI_W-1:0]  sel_hi;
  logic [31:0]      csr_rd_val;

  logic [31:0]      pc_plus4;
  logic [31:0]      next_pc;
  logic [31:0]      rd_val;

  logic             unused_wdata;
  assign unused_wdata = ^csr_wdata[31:INH_W];

  // ---------------------------------------------------------------- counters
  assign presc_wrap = (presc_q == PS_W'(TIME_DIV - 1));

  // Time prescaler: counts 0..TIME_DIV-1, wrap produces one time tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_wrap ? '0 : presc_q + PS_W'(1);
    end
  end

  assign cnt_inc[0] = ~inhibit_q[INH_CY];
  assign cnt_inc[1] = presc_wrap;
  assign cnt_inc[2] = enable_pc & ~inhibit_q[INH_IR];

  ctr_unit #(.W(CNT_W)) u_cycle   (.clk(clk), .rst(rst), .inc_en(cnt_inc[0]), .value(cnt_val[0]));
  ctr_unit #(.W(CNT_W)) u_time    (.clk(clk), .rst(rst), .inc_en(cnt_inc[1]), .value(cnt_val[1]));
  ctr_unit #(.W(CNT_W)) u_instret (.clk(clk), .rst(rst), .inc_en(cnt_inc[2]), .value(cnt_val[2]));

  for (genvar k = 0; k < N_HPM; k++) begin : g_hpm
    assign cnt_inc[3+k] = hpm_event[k] & ~inhibit_q[INH_HPM0+k];
    ctr_unit #(.W(CNT_W)) u_hpm (.clk(clk), .rst(rst), .inc_en(cnt_inc[3+k]), .value(cnt_val[3+k]));
  end

  // --------------------------------------------------------------- CSR port
  assign csr_idx   = csr_addr[3:0];
  assign csr_hi    = csr_addr[CSR_HI_BIT];
  assign cnt_hit   = (csr_addr[11:8] == CSR_CNT_PAGE) && (csr_addr[6:4] == 3'd0)
                     && (csr_idx < 4'(N_CNT));
  assign tag_match = tag_vld_q && (tag_idx_q == csr_idx);

  // Access FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CSR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Access FSM next state: accept a request only when idle, then ack once
  always_comb begin
    state_d = state_q;
    csr_ack = 1'b0;
    csr_go  = 1'b0;
    case (state_q)
      CSR_IDLE: begin
        if (csr_req) begin
          csr_go  = 1'b1;
          state_d = CSR_ACK;
        end
      end
      CSR_ACK: begin
        csr_ack = 1'b1;
        state_d = CSR_IDLE;
      end
      default: state_d = CSR_IDLE;
    endcase
  end

  // Select the addressed counter's low word and upper bits
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (csr_idx == 4'(i)) begin
        sel_lo = cnt_val[i][31:0];
        sel_hi = cnt_val[i][CNT_W-1:32];
      end
    end
  end

  // Read data mux; a tagged high-half read returns the snapshot taken by
  // the preceding low-half read so a 64-bit read is consistent
  always_comb begin
    csr_rd_val = '0;
    if (csr_addr == CSR_INHIBIT) begin
      csr_rd_val = 32'(inhibit_q);
    end else if (cnt_hit) begin
      if (!csr_hi) begin
        csr_rd_val = sel_lo;
      end else if (tag_match) begin
        csr_rd_val = 32'(shadow_q);
      end else begin
        csr_rd_val = 32'(sel_hi);
      end
    end
  end

  // Access side effects: read data capture, shadow snapshot, inhibit write
  always_ff @(posedge clk) begin
    if (!rst) begin
      csr_rdata <= '0;
      inhibit_q <= '0;
      shadow_q  <= '0;
      tag_vld_q <= 1'b0;
      tag_idx_q <= '0;
    end else if (csr_go) begin
      csr_rdata <= csr_rd_val;
      if (csr_we && (csr_addr == CSR_INHIBIT)) begin
        inhibit_q <= csr_wdata[INH_W-1:0] & INH_WMASK;
      end
      if (!csr_we && cnt_hit) begin
        if (!csr_hi) begin
          shadow_q  <= sel_hi;
          tag_vld_q <= 1'b1;
          tag_idx_q <= csr_idx;
        end else if (tag_match) begin
          tag_vld_q <= 1'b0;
        end
      end
    end
  end

  // ------------------------------------------------------------ PC and rd
  assign pc_plus4 = pc + 32'd4;

  // Next-PC priority: interrupt, branch, JALR, JAL, RETIRQ, sequential
  always_comb begin
    next_pc = pc_plus4;
    if (irr) begin
      next_pc = irr_dest;
    end else if (opcode[6:0] == OP_BR7) begin
      next_pc = branch ? (pc + imm) : pc_plus4;
    end else if (opcode == OP_JALR) begin
      next_pc = (rs1 + imm) & ~32'd1;
    end else if (opcode == OP_JAL) begin
      next_pc = pc + imm;
    end else if (opcode == OP_RETIRQ) begin
      next_pc = irr_ret;
    end
  end

  assign misalign = |next_pc[1:0];

  // PC register loads on every commit strobe, even when misaligned
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (enable_pc) begin
      pc <= next_pc;
    end
  end

  // Result mux for the opcodes that write rd here
  always_comb begin
    rd_val = '0;
    is_rd  = 1'b0;
    case (opcode)
      OP_CSRR:         begin rd_val = csr_rdata; is_rd = 1'b1; end
      OP_JAL, OP_JALR: begin rd_val = pc_plus4;  is_rd = 1'b1; end
      OP_AUIPC:        begin rd_val = pc + imm;  is_rd = 1'b1; end
      OP_LUI:          begin rd_val = imm;       is_rd = 1'b1; end
      default:         ;
    endcase
  end

  assign is_inst = is_rd;
  assign rd      = is_rd ? rd_val : 32'hzzzzzzzz;

endmodule

// File: tb/tb_utility_ctr_pc.sv
// Self-checking bench for utility_ctr_pc: directed vector table, hand
// sequences for CSR timing / reset / inhibit / atomic reads, and random
// stimulus checked against a counting reference model.
module tb_utility_ctr_pc;

  localparam int          N_HPM    = 2;
  localparam int          N_CNT    = 3 + N_HPM;
  localparam longint      TIME_DIV = 4;
  localparam logic [31:0] RST_PC   = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_pc;
  logic [11:0] opcode;
  logic [31:0] imm, rs1, irr_dest, irr_ret;
  logic        branch, irr;
  logic [N_HPM-1:0] hpm_event;
  logic        csr_req, csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_ack;
  logic [31:0] csr_rdata, rd, pc;
  logic        is_rd, is_inst, misalign;

  utility_ctr_pc #(.CNT_W(64), .TIME_DIV(4), .N_HPM(N_HPM), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .enable_pc(enable_pc), .opcode(opcode), .imm(imm), .rs1(rs1),
    .branch(branch), .irr(irr), .irr_dest(irr_dest), .irr_ret(irr_ret),
    .hpm_event(hpm_event), .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_ack(csr_ack), .csr_rdata(csr_rdata), .rd(rd),
    .is_rd(is_rd), .is_inst(is_inst), .pc(pc), .misalign(misalign));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit              model_on = 1'b1;
  longint unsigned m_cycle, m_ticks, m_instret;
  longint unsigned m_hpm [N_HPM];
  logic [4:0]      m_inh = '0;
  logic            m_ack = 1'b0;
  logic [31:0]     m_rdata = '0;
  logic [31:0]     m_pc = '0;
  logic [31:0]     m_shadow = '0;
  bit              m_tag_vld = 1'b0;
  int              m_tag_idx = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_cnt(input int i);
    case (i)
      0:       return m_cycle;
      1:       return m_ticks / TIME_DIV;
      2:       return m_instret;
      default: return m_hpm[i-3];
    endcase
  endfunction

  function automatic logic [31:0] m_next_pc(input logic [31:0] p);
    if (irr) return irr_dest;
    if (opcode[6:0] == 7'h63) return branch ? p + imm : p + 32'd4;
    if (opcode == 12'h067) return (rs1 + imm) & 32'hFFFF_FFFE;
    if (opcode == 12'h06F) return p + imm;
    if (opcode == 12'h398) return irr_ret;
    return p + 32'd4;
  endfunction

  // One clock: predict the effect of the inputs at this edge, then compare
  task automatic tick();
    logic        ack_n;
    logic [31:0] rdata_n, pc_n, rv;
    logic [63:0] cv;
    logic [4:0]  inh_old;
    ack_n   = 1'b0;
    rdata_n = m_rdata;
    pc_n    = m_pc;
    if (!rst) begin
      m_cycle = 0; m_ticks = 0; m_instret = 0;
      for (int k = 0; k < N_HPM; k++) m_hpm[k] = 0;
      m_inh = '0; m_shadow = '0; m_tag_vld = 1'b0; m_tag_idx = 0;
      rdata_n = '0;
      pc_n    = RST_PC;
    end else begin
      inh_old = m_inh;
      if (csr_req && !m_ack) begin
        rv = 32'd0;
        if (csr_addr == 12'h320) rv = {27'd0, m_inh};
        for (int i = 0; i < N_CNT; i++) begin
          cv = m_cnt(i);
          if (csr_addr == 12'hC00 + 12'(i)) begin
            rv = cv[31:0];
            if (!csr_we) begin
              m_shadow = cv[63:32]; m_tag_vld = 1'b1; m_tag_idx = i;
            end
          end else if (csr_addr == 12'hC80 + 12'(i)) begin
            if (m_tag_vld && m_tag_idx == i) begin
              rv = m_shadow;
              if (!csr_we) m_tag_vld = 1'b0;
            end else begin
              rv = cv[63:32];
            end
          end
        end
        if (csr_we && csr_addr == 12'h320) m_inh = csr_wdata[4:0] & 5'b11101;
        ack_n   = 1'b1;
        rdata_n = rv;
      end
      if (!inh_old[0]) m_cycle++;
      m_ticks++;
      if (enable_pc && !inh_old[2]) m_instret++;
      for (int k = 0; k < N_HPM; k++) if (hpm_event[k] && !inh_old[3+k]) m_hpm[k]++;
      if (enable_pc) pc_n = m_next_pc(m_pc);
    end
    @(posedge clk);
    #1;
    m_ack   = ack_n;
    m_rdata = rdata_n;
    m_pc    = pc_n;
    if (model_on) begin
      check("pc", pc, m_pc);
      check("csr_ack", {31'd0, csr_ack}, {31'd0, m_ack});
      if (m_ack) check("csr_rdata", csr_rdata, m_rdata);
    end
  endtask

  task automatic comb_check();
    logic [31:0] np, er;
    logic        ev;
    np = m_next_pc(m_pc);
    ev = 1'b1;
    case (opcode)
      12'h073:          er = m_rdata;
      12'h06F, 12'h067: er = m_pc + 32'd4;
      12'h017:          er = m_pc + imm;
      12'h037:          er = imm;
      default: begin ev = 1'b0; er = '0; end
    endcase
    check("is_rd", {31'd0, is_rd}, {31'd0, ev});
    check("is_inst", {31'd0, is_inst}, {31'd0, ev});
    if (ev) check("rd", rd, er);
    check("misalign", {31'd0, misalign}, {31'd0, |np[1:0]});
  endtask

  task automatic idle_inputs();
    enable_pc = 0; opcode = 12'h013; imm = 0; rs1 = 0; branch = 0; irr = 0;
    irr_dest = 0; irr_ret = 0; hpm_event = '0;
    csr_req = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Single CSR access; ack must appear for exactly one cycle
  task automatic csr_op(input logic [11:0] a, input logic we, input logic [31:0] wd,
                        output logic [31:0] rdat);
    csr_req = 1'b1; csr_addr = a; csr_we = we; csr_wdata = wd;
    tick();
    csr_req = 1'b0; csr_we = 1'b0;
    check("ack_high", {31'd0, csr_ack}, 32'd1);
    rdat = csr_rdata;
    tick();
    check("ack_one_cycle", {31'd0, csr_ack}, 32'd0);
  endtask

  typedef struct {
    logic [11:0] op;
    logic [31:0] imm, rs1;
    logic        br, irq;
    logic [31:0] dest, ret;
    logic        exp_is_rd;
    logic [31:0] exp_rd, exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t        vecs [15];
  logic [11:0] ops [10];
  logic [11:0] addrs [15];

  initial begin : main
    logic [31:0] r;
    rst = 1'b0;
    idle_inputs();

    // vectors assume pc = 32'h100 and csr_rdata = 0 (fresh reset)
    vecs[0]  = '{12'h037, 32'h1234_5000, 32'h0,         0, 0, 32'h0,   32'h0,    1, 32'h1234_5000, 32'h104,  0};
    vecs[1]  = '{12'h017, 32'h10,        32'h0,         0, 0, 32'h0,   32'h0,    1, 32'h110,       32'h104,  0};
    vecs[2]  = '{12'h06F, 32'h20,        32'h0,         0, 0, 32'h0,   32'h0,    1, 32'h104,       32'h120,  0};
    vecs[3]  = '{12'h06F, 32'h2,         32'h0,         0, 0, 32'h0,   32'h0,    1, 32'h104,       32'h102,  1};
    vecs[4]  = '{12'h067, 32'h10,        32'h2001,      0, 0, 32'h0,   32'h0,    1, 32'h104,       32'h2010, 0};
    vecs[5]  = '{12'h063, 32'hFFFF_FFF0, 32'h0,         1, 0, 32'h0,   32'h0,    0, 32'h0,         32'hF0,   0};
    vecs[6]  = '{12'h063, 32'hFFFF_FFF0, 32'h0,         0, 0, 32'h0,   32'h0,    0, 32'h0,         32'h104,  0};
    vecs[7]  = '{12'h0E3, 32'h8,         32'h0,         1, 0, 32'h0,   32'h0,    0, 32'h0,         32'h108,  0};
    vecs[8]  = '{12'h398, 32'h0,         32'h0,         0, 0, 32'h0,   32'h4000, 0, 32'h0,         32'h4000, 0};
    vecs[9]  = '{12'h06F, 32'h20,        32'h0,         0, 1, 32'h500, 32'h0,    1, 32'h104,       32'h500,  0};
    vecs[10] = '{12'h013, 32'h0,         32'h0,         0, 0, 32'h0,   32'h0,    0, 32'h0,         32'h104,  0};
    vecs[11] = '{12'h073, 32'h0,         32'h0,         0, 0, 32'h0,   32'h0,    1, 32'h0,         32'h104,  0};
    vecs[12] = '{12'h017, 32'hFFFF_FF00, 32'h0,         0, 0, 32'h0,   32'h0,    1, 32'h0,         32'h104,  0};
    vecs[13] = '{12'h067, 32'h2,         32'hFFFF_FFFF, 0, 0, 32'h0,   32'h0,    1, 32'h104,       32'h0,    0};
    vecs[14] = '{12'h398, 32'h0,         32'h0,         0, 0, 32'h0,   32'h4003, 0, 32'h0,         32'h4003, 1};

    ops   = '{12'h013, 12'h037, 12'h017, 12'h06F, 12'h067, 12'h063, 12'h0E3, 12'h398, 12'h073, 12'h7FF};
    addrs = '{12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'hC04, 12'hC80, 12'hC81, 12'hC82,
              12'hC83, 12'hC84, 12'h320, 12'hC05, 12'hC85, 12'h123, 12'h000};

    // reset state and first commit
    do_reset();
    check("reset_pc", pc, 32'h100);
    check("reset_ack", {31'd0, csr_ack}, 32'd0);
    check("reset_rdata", csr_rdata, 32'd0);
    enable_pc = 1'b1; opcode = 12'h013;
    tick();
    check("first_commit_pc", pc, 32'h104);

    // time prescale: 12 idle cycles after reset
    do_reset();
    for (int i = 0; i < 12; i++) tick();
    csr_op(12'hC00, 1'b0, 32'd0, r);
    check("cycle_after_12", r, 32'd12);
    csr_op(12'hC01, 1'b0, 32'd0, r);
    check("time_after_14", r, 32'd3);

    // reset during an access drops it
    csr_req = 1'b1; csr_addr = 12'hC00; rst = 1'b0;
    tick();
    check("rst_mid_ack", {31'd0, csr_ack}, 32'd0);
    check("rst_mid_rdata", csr_rdata, 32'd0);
    csr_req = 1'b0; rst = 1'b1;
    tick();
    check("rst_mid_ack2", {31'd0, csr_ack}, 32'd0);

    // request held through the ack cycle: ack pattern 1,0,1
    csr_req = 1'b1; csr_addr = 12'hC02;
    tick(); check("held_req_ack0", {31'd0, csr_ack}, 32'd1);
    tick(); check("held_req_ack1", {31'd0, csr_ack}, 32'd0);
    tick(); check("held_req_ack2", {31'd0, csr_ack}, 32'd1);
    csr_req = 1'b0;
    tick(); check("held_req_ack3", {31'd0, csr_ack}, 32'd0);

    // inhibit cycle and instret, hpm0 keeps counting
    do_reset();
    csr_op(12'h320, 1'b1, 32'h5, r);
    for (int i = 0; i < 6; i++) begin
      enable_pc = 1'b1; opcode = 12'h013;
      hpm_event = (i % 2 == 0) ? 2'b01 : 2'b00;
      tick();
    end
    enable_pc = 1'b0; hpm_event = '0;
    csr_op(12'hC00, 1'b0, 32'd0, r); check("inh_cycle_frozen", r, 32'd1);
    csr_op(12'hC02, 1'b0, 32'd0, r); check("inh_instret_frozen", r, 32'd0);
    csr_op(12'hC03, 1'b0, 32'd0, r); check("inh_hpm0_counts", r, 32'd3);
    csr_op(12'h320, 1'b0, 32'd0, r); check("inh_readback", r, 32'h5);
    csr_op(12'h320, 1'b1, 32'hFFFF_FFFF, r);
    csr_op(12'h320, 1'b0, 32'd0, r); check("inh_bit1_forced0", r, 32'h1D);
    csr_op(12'hC05, 1'b0, 32'd0, r); check("unmapped_zero", r, 32'd0);

    // JALR target and misalign
    do_reset();
    opcode = 12'h067; rs1 = 32'h1001; imm = 32'h0; enable_pc = 1'b1;
    #1;
    check("jalr_rd", rd, 32'h104);
    check("jalr_mis0", {31'd0, misalign}, 32'd0);
    tick();
    check("jalr_pc", pc, 32'h1000);
    rs1 = 32'h1002;
    #1;
    check("jalr_mis1", {31'd0, misalign}, 32'd1);
    check("jalr_rd2", rd, 32'h1004);
    tick();
    check("jalr_pc_mis", pc, 32'h1002);

    // interrupt beats a taken branch; unknown opcode drives nothing
    irr = 1'b1; irr_dest = 32'h80; opcode = 12'h063; branch = 1'b1; imm = 32'h40;
    tick();
    check("irr_priority_pc", pc, 32'h80);
    irr = 1'b0; enable_pc = 1'b0; opcode = 12'h7FF;
    #1;
    check("unknown_is_rd", {31'd0, is_rd}, 32'd0);
    check("unknown_is_inst", {31'd0, is_inst}, 32'd0);

    // directed vector table
    for (int v = 0; v < 15; v++) begin
      do_reset();
      opcode = vecs[v].op; imm = vecs[v].imm; rs1 = vecs[v].rs1; branch = vecs[v].br;
      irr = vecs[v].irq; irr_dest = vecs[v].dest; irr_ret = vecs[v].ret;
      #1;
      check("vec_is_rd", {31'd0, is_rd}, {31'd0, vecs[v].exp_is_rd});
      check("vec_is_inst", {31'd0, is_inst}, {31'd0, vecs[v].exp_is_rd});
      if (vecs[v].exp_is_rd) check("vec_rd", rd, vecs[v].exp_rd);
      check("vec_misalign", {31'd0, misalign}, {31'd0, vecs[v].exp_mis});
      enable_pc = 1'b1;
      tick();
      check("vec_pc", pc, vecs[v].exp_pc);
    end

    // random stimulus against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(0, 299) != 0);
      enable_pc = 1'($urandom_range(0, 1));
      opcode    = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) opcode = 12'($urandom);
      imm       = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      rs1       = $urandom;
      branch    = 1'($urandom_range(0, 1));
      irr       = ($urandom_range(0, 15) == 0);
      irr_dest  = $urandom;
      irr_ret   = $urandom;
      hpm_event = N_HPM'($urandom);
      csr_req   = ($urandom_range(0, 2) == 0);
      csr_addr  = addrs[$urandom_range(0, 14)];
      csr_we    = (csr_addr == 12'h320) && ($urandom_range(0, 1) == 1);
      csr_wdata = $urandom;
      #1;
      comb_check();
      tick();
    end

    // atomic 64-bit read across a carry into the high word
    model_on = 1'b0;
    do_reset();
    force dut.u_cycle.cnt_q = 64'h0000_0000_FFFF_FFFE;
    csr_op(12'hC00, 1'b0, 32'd0, r); check("atomic_lo", r, 32'hFFFF_FFFE);
    force dut.u_cycle.cnt_q = 64'h0000_0001_0000_0003;
    csr_op(12'hC80, 1'b0, 32'd0, r); check("atomic_hi_shadow", r, 32'd0);
    csr_op(12'hC80, 1'b0, 32'd0, r); check("atomic_hi_live", r, 32'd1);
    release dut.u_cycle.cnt_q;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d errors of %0d checks", n_err, n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/utility_ctr_pc.md
Name: utility_ctr_pc

Overview:
- Successor to the core's PC/counter utility block. Holds the program counter and the next-PC selection.
- Produces rd for LUI/AUIPC/JAL/JALR/CSRR.
- Counters: parametrised cycle, time and instret counters, plus N_HPM event counters.
- CSR accesses use a req/ack port. Reads of 64-bit counters are atomic across halves via a shadow register. A writable counter-inhibit CSR is included.

Parameters:
- CNT_W, 64, counter width (33..64); high-half reads zero-extend bits [CNT_W-1:32].
- TIME_DIV, 100, clk cycles per time tick (>=2).
- N_HPM, 2, event counters (1..8).
- RESET_PC, 32'h0, PC value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- enable_pc  in  1  commit strobe: PC update and instret increment
- opcode  in  12  decoded opcode
- imm  in  32  immediate / CSR address (imm[11:0])
- rs1  in  32  JALR base
- branch  in  1  branch taken
- irr  in  1  interrupt redirect
- irr_dest  in  32  interrupt target
- irr_ret  in  32  RETIRQ target
- hpm_event  in  N_HPM  per-cycle event pulses
- csr_req  in  1  CSR access request
- csr_we  in  1  write qualifier
- csr_addr  in  12  CSR address
- csr_wdata  in  32  write data
- csr_ack  out  1  one-cycle access done
- csr_rdata  out  32  registered read data
- rd  out  32  result; 32'hzzzzzzzz when is_rd=0
- is_rd  out  1  rd driven
- is_inst  out  1  opcode handled here
- pc  out  32  current PC
- misalign  out  1  computed next PC [1:0] != 0

Behaviour:
- Reset is rst, synchronous, active-low; clock is clk.
- Values on reset:
  - pc = RESET_PC.
  - All counters, prescaler, inhibit and shadow = 0.
  - csr_ack = 0, csr_rdata = 0.
  - Reset mid-access drops the access; no ack.
- Cycle counter: +1 every clk unless inhibit[0]=1.
- Time counter:
  - The prescaler counts 0..TIME_DIV-1.
  - At TIME_DIV-1 the prescaler wraps to 0 and time increments.
  - Time is never inhibited.
- Instret counter: +1 when enable_pc=1 and inhibit[2]=0.
- HPM counter k: +1 when hpm_event[k]=1 and inhibit[3+k]=0.
- Counter wrap: all counters wrap modulo 2^CNT_W.
- CSR addresses (low/high halves):
  - cycle C00/C80, time C01/C81, instret C02/C82.
  - hpm k: C03+k / C83+k.
  - Inhibit register at 320.
- CSR handshake:
  - csr_req sampled at a posedge with csr_ack=0.
  - Next cycle: csr_ack=1 for exactly one cycle, with csr_rdata valid. csr_rdata holds until the next access.
  - csr_req during the ack cycle is ignored; the requester re-asserts.
- CSR reads:
  - Low-half read: returns live bits [31:0] and captures live upper bits into the shadow, tagged with the counter index.
  - High-half read:
    - Tag matches: returns the shadow and clears the tag.
    - Otherwise: returns the live upper bits.
  - Unmapped addresses read 0.
- CSR writes:
  - csr_we=1 to 320 writes inhibit[2+N_HPM:0]; bit 1 is forced 0.
  - Writes to any other address are ignored but still acked.
- Opcode-to-rd mapping (combinational):
  - 12'h073 CSRR: rd = csr_rdata.
  - 12'h06F JAL: rd = pc+4.
  - 12'h067 JALR: rd = pc+4.
  - 12'h017 AUIPC: rd = pc+imm.
  - 12'h037 LUI: rd = imm.
  - These opcodes set is_rd=1 and is_inst=1. Any other opcode sets both to 0.
- Next PC, priority high to low:
  1. irr: irr_dest.
  2. opcode[6:0]=7'h63 (branch): pc+imm if branch, else pc+4.
  3. JALR: (rs1+imm) & ~1, with LSB cleared.
  4. JAL: pc+imm.
  5. 12'h398 (RETIRQ): irr_ret.
  6. Otherwise: pc+4.
- PC register: loads the next PC at posedge when enable_pc=1.
- misalign: combinational from the next PC. The PC still loads; trapping is the IRQ unit's job.
- Arithmetic: all 32-bit, wrap-around, no overflow flag.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_CSRR, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_BR7, OP_RETIRQ.
  - CSR address constants.
  - INHIBIT bit indices.
- Sub-module ctr_unit (width CNT_W; inc_en in; value out), instantiated 3+N_HPM times. The prescaler is inline.

Test Plan:
- Reset PC: rst=0 for 2 cycles with RESET_PC=32'h100 -> pc=32'h100, csr_ack=0; first enable_pc with opcode 12'h013 -> pc=32'h104.
- Time prescale: TIME_DIV=4, run 12 cycles after reset -> time=3, cycle=12; read C01 -> csr_ack one cycle later, csr_rdata=3.
- Atomic read: preload cycle=64'h0000_0000_FFFF_FFFE, read C00 -> csr_rdata=FFFF_FFFE. Then read C80 with the live high word now 1 -> csr_rdata=0 (shadow). A second C80 read -> 1.
- Inhibit: write 320=32'h5 -> cycle and instret frozen while enable_pc pulses; read 320 -> 32'h5; hpm0 still counts hpm_event[0] pulses.
- JALR: rs1=32'h1001, imm=0, enable_pc -> pc=32'h1000, rd=old pc+4, misalign=0. Then rs1=32'h1002 -> misalign=1.
- Priority: irr=1, irr_dest=32'h80, opcode=7'h63, branch=1 -> pc=32'h80. Unknown opcode 12'h7FF -> is_rd=0, rd=Z.
